// File: rtl/time_readout_if.sv
// Byte-stream side of the time readout: one field byte plus its index, valid/ready handshake.
interface time_readout_if;
  logic [7:0] byte_out;
  logic [1:0] byte_field;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_field,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_field,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/time_readout.sv
// Snapshots the packed 32-bit time word and streams its fields as bytes
// (mil, hour, minute, second) over a valid/ready handshake, either all four
// fields or a single selected one. Optional binary->BCD on hour/min/sec.
module time_readout #(
  parameter bit BCD_OUT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   time_in,
  input  logic          read_all,
  input  logic          read_one,
  input  logic [1:0]    field_sel,
  time_readout_if.master rd,
  output logic          busy,
  output logic          done
);

  localparam int unsigned TIME_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FIELD_W = 2;

  localparam logic [FIELD_W-1:0] FIELD_MIL = FIELD_W'(3);
  localparam logic [FIELD_W-1:0] FIELD_SEC = FIELD_W'(0);
  localparam logic [BYTE_W-1:0]  BCD_MAX   = BYTE_W'(8'h99);
  localparam logic [BYTE_W-1:0]  BIN_MAX   = BYTE_W'(99);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [TIME_W-1:0]    shadow_q, shadow_d;
  logic [FIELD_W-1:0]   field_q, field_d;
  logic                 all_q, all_d;
  logic [BYTE_W-1:0]    byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 req_c;
  logic                 xfer_c;
  logic                 last_c;
  logic [FIELD_W-1:0]   start_field_c;
  logic [FIELD_W-1:0]   next_field_c;

  // Binary to packed BCD, saturating anything above 99 to 99.
  function automatic logic [BYTE_W-1:0] to_bcd(input logic [BYTE_W-1:0] v);
    if (v > BIN_MAX) begin
      return BCD_MAX;
    end
    return {4'(v / BYTE_W'(10)), 4'(v % BYTE_W'(10))};
  endfunction

  // Select one field of a time word and apply the output format.
  function automatic logic [BYTE_W-1:0] field_byte(input logic [TIME_W-1:0]  word,
                                                   input logic [FIELD_W-1:0] f);
    logic [BYTE_W-1:0] raw;
    case (f)
      2'd3:    raw = word[31:24];
      2'd2:    raw = word[23:16];
      2'd1:    raw = word[15:8];
      default: raw = word[7:0];
    endcase
    if (BCD_OUT && (f != FIELD_MIL)) begin
      return to_bcd(raw);
    end
    return raw;
  endfunction

  // State and output registers; reset aborts any readout in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      field_q  <= '0;
      all_q    <= 1'b0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      field_q  <= field_d;
      all_q    <= all_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; the byte for the following beat is formatted here.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    field_d  = field_q;
    all_d    = all_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    req_c         = read_all || read_one;
    xfer_c        = valid_q && rd.byte_ready;
    last_c        = !all_q || (field_q == FIELD_SEC);
    start_field_c = read_all ? FIELD_MIL : field_sel;
    next_field_c  = FIELD_W'(field_q - FIELD_W'(1));

    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_d  = SEND;
          shadow_d = time_in;
          all_d    = read_all;
          field_d  = start_field_c;
          byte_d   = field_byte(time_in, start_field_c);
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SEND: begin
        if (xfer_c) begin
          if (last_c) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            field_d = next_field_c;
            byte_d  = field_byte(shadow_q, next_field_c);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd.byte_out   = byte_q;
  assign rd.byte_field = field_q;
  assign rd.byte_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_time_readout.sv
// Randomized bench for time_readout: a binary and a BCD instance share stimulus
// and are compared against an expected-byte list built from the time word.
module tb_time_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] time_in;
  logic        read_all;
  logic        read_one;
  logic [1:0]  field_sel;
  logic        ready;
  logic        busy_b, done_b, busy_d, done_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  time_readout_if if_bin ();
  time_readout_if if_bcd ();

  assign if_bin.byte_ready = ready;
  assign if_bcd.byte_ready = ready;

  time_readout #(.BCD_OUT(1'b0)) u_bin (
    .clk       (clk),
    .rst       (rst),
    .time_in   (time_in),
    .read_all  (read_all),
    .read_one  (read_one),
    .field_sel (field_sel),
    .rd        (if_bin),
    .busy      (busy_b),
    .done      (done_b)
  );

  time_readout #(.BCD_OUT(1'b1)) u_bcd (
    .clk       (clk),
    .rst       (rst),
    .time_in   (time_in),
    .read_all  (read_all),
    .read_one  (read_one),
    .field_sel (field_sel),
    .rd        (if_bcd),
    .busy      (busy_d),
    .done      (done_d)
  );

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected byte for a field: shift out the field, optional decimal re-encoding.
  function automatic logic [7:0] model_byte(input logic [31:0] t, input int f, input bit bcd);
    int v;
    v = int'((t >> (8 * f)) & 32'hFF);
    if (bcd && f != 3) begin
      if (v > 99) v = 'h99;
      else        v = (v / 10) * 16 + (v % 10);
    end
    return 8'(v);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid_bin"}, 32'(if_bin.byte_valid), 32'd0);
    check({tag, "_valid_bcd"}, 32'(if_bcd.byte_valid), 32'd0);
    check({tag, "_busy"},      32'({busy_b, busy_d}),   32'd0);
    check({tag, "_done"},      32'({done_b, done_d}),   32'd0);
  endtask

  // One readout starting at a negedge. rmode: 0 always ready, 1 random ready,
  // 2 ready low for 3 cycles on the 2nd byte. noise disturbs time_in/requests mid-readout.
  // b2b leaves the bench on the done cycle so the caller can request again at once.
  task automatic do_read(input bit all, input bit one, input logic [1:0] sel,
                         input logic [31:0] t, input int rmode, input bit noise, input bit b2b);
    int fields[$];
    int stalls;
    bit go;
    logic [31:0] snap;
    if (all) fields = {3, 2, 1, 0};
    else     fields = {int'(sel)};
    snap      = t;
    time_in   = t;
    read_all  = all;
    read_one  = one;
    field_sel = sel;
    ready     = 1'b0;
    @(negedge clk);
    read_all = 1'b0;
    read_one = 1'b0;
    for (int i = 0; i < fields.size(); i++) begin
      stalls = 0;
      forever begin
        check("valid", 32'({if_bin.byte_valid, if_bcd.byte_valid}), 32'd3);
        check("busy",  32'({busy_b, busy_d}), 32'd3);
        check("done_low", 32'({done_b, done_d}), 32'd0);
        check("field_bin", 32'(if_bin.byte_field), 32'(fields[i]));
        check("field_bcd", 32'(if_bcd.byte_field), 32'(fields[i]));
        check("byte_bin", 32'(if_bin.byte_out), 32'(model_byte(snap, fields[i], 1'b0)));
        check("byte_bcd", 32'(if_bcd.byte_out), 32'(model_byte(snap, fields[i], 1'b1)));
        if (noise) begin
          if (i == 1 && stalls == 0) begin
            time_in  = 32'h0;
            read_all = 1'b1;
            read_one = 1'b1;
          end else begin
            time_in   = $urandom;
            read_all  = 1'($urandom % 2);
            read_one  = 1'($urandom % 2);
            field_sel = 2'($urandom % 4);
          end
        end
        case (rmode)
          0:       go = 1'b1;
          2:       go = !(i == 1 && stalls < 3);
          default: go = ($urandom % 3 != 0) || (stalls >= 4);
        endcase
        ready = go;
        @(negedge clk);
        if (go) break;
        stalls++;
      end
    end
    read_all = 1'b0;
    read_one = 1'b0;
    ready    = 1'($urandom % 2);
    check("done_pulse", 32'({done_b, done_d}), 32'd3);
    check("end_valid",  32'({if_bin.byte_valid, if_bcd.byte_valid}), 32'd0);
    check("end_busy",   32'({busy_b, busy_d}), 32'd0);
    if (!b2b) begin
      @(negedge clk);
      check_idle("after_done");
    end
  endtask

  logic [7:0] edge_vals [6];

  initial begin
    bit all, one, b2b;
    logic [31:0] t;
    edge_vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};

    // T1: reset held with a request pending
    rst       = 1'b1;
    read_all  = 1'b1;
    read_one  = 1'b0;
    field_sel = 2'd0;
    time_in   = 32'h12345678;
    ready     = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_byte",  32'({if_bin.byte_out, if_bcd.byte_out}), 32'd0);
    check("reset_field", 32'({if_bin.byte_field, if_bcd.byte_field}), 32'd0);
    rst      = 1'b0;
    read_all = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // T2: full read, always ready
    do_read(1'b1, 1'b0, 2'd0, 32'h010D2A3B, 0, 1'b0, 1'b0);
    // T3: backpressure on 2nd byte
    do_read(1'b1, 1'b0, 2'd0, 32'h010D2A3B, 2, 1'b0, 1'b0);
    // T4: time_in changes and requests mid-readout are ignored
    do_read(1'b1, 1'b0, 2'd2, 32'h010D2A3B, 1, 1'b1, 1'b0);
    // T5: single field
    do_read(1'b0, 1'b1, 2'd1, 32'h00000F00, 0, 1'b0, 1'b0);
    // read_all wins over read_one
    do_read(1'b1, 1'b1, 2'd0, 32'hFF63643A, 0, 1'b0, 1'b1);
    // back-to-back: request accepted in the done cycle
    do_read(1'b0, 1'b1, 2'd3, 32'h7F000000, 1, 1'b0, 1'b0);
    // T6: decimal conversion incl. saturation, then reset mid-readout
    do_read(1'b1, 1'b0, 2'd0, 32'h010D2AC8, 0, 1'b0, 1'b0);

    time_in  = 32'h010D2AC8;
    read_all = 1'b1;
    ready    = 1'b1;
    @(negedge clk);
    read_all = 1'b0;
    check("abort_b0", 32'(if_bcd.byte_out), 32'h01);
    @(negedge clk);
    check("abort_b1", 32'(if_bcd.byte_out), 32'h13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort_rst");
    check("abort_byte", 32'({if_bin.byte_out, if_bcd.byte_out}), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check_idle("abort_quiet");
    end

    // Random readouts with boundary field values mixed in
    for (int n = 0; n < 60; n++) begin
      t = $urandom;
      for (int k = 0; k < 4; k++) begin
        if ($urandom % 3 == 0) t[8*k +: 8] = edge_vals[$urandom_range(0, 5)];
      end
      all = 1'($urandom % 2);
      one = all ? 1'($urandom % 2) : 1'b1;
      b2b = (n != 59) && ($urandom % 3 == 0);
      do_read(all, one, 2'($urandom % 4), t, int'($urandom % 3),
              1'($urandom % 2), b2b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
